es9821q_cfg_sequencer: RTL
==========================

Name: es9821q_cfg_sequencer

Overview:
Power-up configuration sequencer for the ES9821Q ADC and the companion DAC. It walks a fixed register table of (target, reg, data) entries and issues each entry as one register write to a shared byte-level I2C write engine over a valid/ready command and response handshake. It retries NACKed writes and reports done or error status. The status outputs gate the I2S/FIFO audio path, which is held off until configuration completes.

Parameters:
NUM_ENTRIES, 16, number of table entries (1..64)
ADC_ADDR, 7'h40, 7-bit I2C address of the ADC
DAC_ADDR, 7'h48, 7-bit I2C address of the DAC
POR_DELAY, 1000, clk cycles to wait after start before the first write (>=1)
MAX_RETRY, 3, extra attempts per entry after a NACK (0..7)
RETRY_GAP, 256, clk cycles of idle between a NACK and the retry (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; sampled only in IDLE, DONE and ERROR
cmd_valid  out  1  write command valid to the I2C engine
cmd_ready  in  1  engine accepts the command when cmd_valid && cmd_ready
cmd_dev_addr  out  7  target device address
cmd_reg  out  8  register address
cmd_data  out  8  register data
rsp_valid  in  1  one-cycle pulse; the transfer is finished
rsp_nack  in  1  qualified by rsp_valid; 1 = any byte NACKed
busy  out  1  sequence in progress
cfg_done  out  1  all entries written; sticky until the next start
cfg_error  out  1  an entry failed after all retries; sticky until the next start
err_index  out  6  index of the failing entry; valid while cfg_error=1
cur_index  out  6  entry currently being processed

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- States: IDLE, POR_WAIT, ISSUE, WAIT_RSP, RETRY_WAIT, DONE, ERROR.
- IDLE/DONE/ERROR with start=1 (next cycle):
  - go to POR_WAIT.
  - clear cfg_done, cfg_error, err_index, cur_index and the retry count.
  - assert busy.
- POR_WAIT: count POR_DELAY cycles, then go to ISSUE. start is ignored while busy.
- ISSUE:
  - cmd_valid=1 with registered fields from the table entry at cur_index.
  - cmd_dev_addr = ADC_ADDR when the entry target bit=0, DAC_ADDR when 1.
  - Fields stay stable while cmd_valid=1 && !cmd_ready.
  - On handshake, cmd_valid drops the next cycle and the state goes to WAIT_RSP.
- WAIT_RSP: wait for rsp_valid. No timeout; the engine guarantees a response.
  - ACK and cur_index=NUM_ENTRIES-1 -> DONE. cfg_done=1, busy=0.
  - ACK otherwise -> cur_index+1, retry count cleared, back to ISSUE.
  - NACK and retry count < MAX_RETRY -> increment the retry count, go to RETRY_WAIT.
  - NACK and retry count = MAX_RETRY -> ERROR. cfg_error=1, err_index=cur_index, busy=0.
- RETRY_WAIT: count RETRY_GAP cycles, then ISSUE with the same entry.
- rsp_valid outside WAIT_RSP is ignored.
- Minimum per-entry latency: 1 cycle from entering ISSUE to handshake (cmd_ready=1), then the engine time.
- Reset mid-operation: immediate return to IDLE and cmd_valid=0. The engine is reset by the same rst_n.
- cfg_done and cfg_error are never both 1.

Decomposition:
- Shared package es9821q_pkg holds:
  - entry field widths (target 1b, reg 8b, data 8b)
  - the state encoding constants
  - the default ES9821Q/DAC register table contents
- Sub-module es9821q_cfg_rom: combinational index[5:0] -> {target, reg, data}. Out-of-range indices return {0, 8'h00, 8'h00}.

Test Plan:
- Reset, then start=1 with NUM_ENTRIES=4, POR_DELAY=10, engine always ACKs with ready=1 -> first cmd_valid exactly 11 cycles after start sampled; 4 commands in table order with correct dev_addr (0x40/0x48); cfg_done=1, busy=0 after the 4th rsp_valid.
- cmd_ready held low for 20 cycles on entry 2 -> cmd_valid and the fields stay stable throughout; exactly one handshake; sequence completes normally.
- Entry 1 NACKs twice then ACKs, MAX_RETRY=3, RETRY_GAP=8 -> entry 1 issued 3 times with >=8 idle cycles between attempts; cur_index never skips; cfg_done=1.
- Entry 3 always NACKs, MAX_RETRY=3 -> 4 attempts on entry 3, then cfg_error=1, err_index=3, cfg_done=0, no entry 4 issued.
- From ERROR, assert start -> flags clear, full sequence reruns from index 0; start pulses while busy have no effect.
- Assert rst_n low during WAIT_RSP on entry 2 -> all outputs 0 immediately; release and restart -> sequence begins at index 0.

Source files
------------

// File: rtl/es9821q_pkg.sv
// Shared types for the ES9821Q power-up configuration sequencer:
// table entry layout, FSM state codes and the default register table.
package es9821q_pkg;

    localparam int TGT_W = 1;
    localparam int REG_W = 8;
    localparam int DAT_W = 8;

    typedef struct packed {
        logic [TGT_W-1:0] target;
        logic [REG_W-1:0] addr;
        logic [DAT_W-1:0] data;
    } cfg_entry_t;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_POR_WAIT   = 3'd1;
    localparam logic [2:0] S_ISSUE      = 3'd2;
    localparam logic [2:0] S_WAIT_RSP   = 3'd3;
    localparam logic [2:0] S_RETRY_WAIT = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;
    localparam logic [2:0] S_ERROR      = 3'd6;

    // target 0 = ADC, 1 = DAC
    function automatic cfg_entry_t cfg_table(input logic [5:0] idx);
        cfg_entry_t e;
        e = '0;
        case (idx)
            6'd0:    e = '{1'b0, 8'h00, 8'h01};
            6'd1:    e = '{1'b1, 8'h01, 8'h80};
            6'd2:    e = '{1'b0, 8'h0B, 8'h24};
            6'd3:    e = '{1'b1, 8'h02, 8'h33};
            6'd4:    e = '{1'b0, 8'h0C, 8'h10};
            6'd5:    e = '{1'b0, 8'h0D, 8'h00};
            6'd6:    e = '{1'b1, 8'h03, 8'h0F};
            6'd7:    e = '{1'b1, 8'h04, 8'hC0};
            6'd8:    e = '{1'b0, 8'h10, 8'h7F};
            6'd9:    e = '{1'b0, 8'h11, 8'h7F};
            6'd10:   e = '{1'b1, 8'h05, 8'h00};
            6'd11:   e = '{1'b1, 8'h06, 8'h00};
            6'd12:   e = '{1'b0, 8'h20, 8'h02};
            6'd13:   e = '{1'b0, 8'h21, 8'h01};
            6'd14:   e = '{1'b1, 8'h07, 8'h01};
            6'd15:   e = '{1'b0, 8'h01, 8'h00};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/es9821q_cfg_sequencer_rom.sv
// Combinational lookup of one configuration table entry.
// Indices at or beyond NUM_ENTRIES read back as an all-zero entry.
module es9821q_cfg_rom
    import es9821q_pkg::*;
#(
    parameter int NUM_ENTRIES = 16
) (
    input  logic [5:0] index_i,
    output cfg_entry_t entry_o
);

    always_comb begin
        entry_o = '0;
        if (int'(index_i) < NUM_ENTRIES) begin
            entry_o = cfg_table(index_i);
        end
    end

endmodule

// File: rtl/es9821q_cfg_sequencer.sv
// Power-up sequencer: walks the register table and issues each entry as
// one write to the shared I2C engine, retrying NACKed writes.
module es9821q_cfg_sequencer
    import es9821q_pkg::*;
#(
    parameter int         NUM_ENTRIES = 16,
    parameter logic [6:0] ADC_ADDR    = 7'h40,
    parameter logic [6:0] DAC_ADDR    = 7'h48,
    parameter int         POR_DELAY   = 1000,
    parameter int         MAX_RETRY   = 3,
    parameter int         RETRY_GAP   = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    output logic       cmd_valid_o,
    input  logic       cmd_ready_i,
    output logic [6:0] cmd_dev_addr_o,
    output logic [7:0] cmd_reg_o,
    output logic [7:0] cmd_data_o,
    input  logic       rsp_valid_i,
    input  logic       rsp_nack_i,
    output logic       busy_o,
    output logic       cfg_done_o,
    output logic       cfg_error_o,
    output logic [5:0] err_index_o,
    output logic [5:0] cur_index_o
);

    localparam int MAXD = (POR_DELAY > RETRY_GAP) ? POR_DELAY : RETRY_GAP;
    localparam int CW   = $clog2(MAXD + 1);

    localparam logic [CW-1:0] POR_LAST  = CW'(POR_DELAY - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(RETRY_GAP - 1);
    localparam logic [5:0]    LAST_IDX  = 6'(NUM_ENTRIES - 1);
    localparam logic [2:0]    RETRY_LIM = 3'(MAX_RETRY);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    retry_q, retry_d;
    logic [5:0]    idx_q, idx_d;
    logic [5:0]    eidx_q, eidx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          vld_q, vld_d;
    logic [6:0]    dev_q, dev_d;
    logic [7:0]    reg_q, reg_d;
    logic [7:0]    dat_q, dat_d;

    cfg_entry_t rom_entry;

    es9821q_cfg_rom #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_rom (
        .index_i(idx_q),
        .entry_o(rom_entry)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        idx_d   = idx_q;
        eidx_d  = eidx_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        vld_d   = vld_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        dat_d   = dat_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    state_d = S_POR_WAIT;
                    cnt_d   = '0;
                    retry_d = '0;
                    idx_d   = '0;
                    eidx_d  = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_POR_WAIT: begin
                if (cnt_q == POR_LAST) begin
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ISSUE: begin
                // first cycle latches the entry, then hold until accepted
                if (!vld_q) begin
                    vld_d = 1'b1;
                    dev_d = rom_entry.target[0] ? DAC_ADDR : ADC_ADDR;
                    reg_d = rom_entry.addr;
                    dat_d = rom_entry.data;
                end else if (cmd_ready_i) begin
                    vld_d   = 1'b0;
                    state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (rsp_valid_i) begin
                    if (!rsp_nack_i) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_ISSUE;
                            idx_d   = idx_q + 6'd1;
                            retry_d = '0;
                        end
                    end else if (retry_q < RETRY_LIM) begin
                        state_d = S_RETRY_WAIT;
                        retry_d = retry_q + 3'd1;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        eidx_d  = idx_q;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_RETRY_WAIT: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            retry_q <= '0;
            idx_q   <= '0;
            eidx_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            idx_q   <= idx_d;
            eidx_q  <= eidx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            dat_q   <= dat_d;
        end
    end

    assign cmd_valid_o    = vld_q;
    assign cmd_dev_addr_o = dev_q;
    assign cmd_reg_o      = reg_q;
    assign cmd_data_o     = dat_q;
    assign busy_o         = busy_q;
    assign cfg_done_o     = done_q;
    assign cfg_error_o    = err_q;
    assign err_index_o    = eidx_q;
    assign cur_index_o    = idx_q;

endmodule
